// File: rtl/rename_prf_core_pkg.sv
// Shared sizing constants and types for the register-renaming core.
package rename_prf_core_pkg;

    localparam int NUM_ARCH = 32;
    localparam int NUM_PHYS = 64;
    localparam int XLEN     = 32;
    localparam int PREG_W   = $clog2(NUM_PHYS);
    localparam int ARCH_W   = $clog2(NUM_ARCH);
    localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int FL_PTR_W = $clog2(FL_DEPTH);
    localparam int FL_CNT_W = $clog2(FL_DEPTH + 1);

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [ARCH_W-1:0] arch_idx_t;

    typedef struct packed {
        preg_t phys_reg;
        logic  ready;
    } tag_t;

endpackage

// File: rtl/rename_prf_core_free_fifo.sv
// Circular free list of physical registers; resets holding pregs NUM_ARCH..NUM_PHYS-1.
// FREE_LIST_BYPASS_EN: while empty, a retiring register is offered directly as the head.
module rename_free_fifo
    import rename_prf_core_pkg::*;
(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              pop_i,
    input  logic              push_i,
    input  logic [PREG_W-1:0] push_preg_i,
    output logic [PREG_W-1:0] head_preg_o,
    output logic              empty_o
);

    preg_t               entries_q [FL_DEPTH];
    logic [FL_PTR_W-1:0] head_q, head_d;
    logic [FL_PTR_W-1:0] tail_q, tail_d;
    logic [FL_CNT_W-1:0] count_q, count_d;
    logic                is_empty, is_full, bypass, do_pop, do_push;

    function automatic logic [FL_PTR_W-1:0] ptr_inc(input logic [FL_PTR_W-1:0] p);
        return (p == FL_PTR_W'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FL_CNT_W'(FL_DEPTH));

`ifdef FREE_LIST_BYPASS_EN
    assign bypass = is_empty & push_i;
`else
    assign bypass = 1'b0;
`endif

    assign head_preg_o = bypass ? push_preg_i : entries_q[head_q];
    assign empty_o     = is_empty & ~bypass;

    // A bypassed register taken by a same-cycle pop never enters storage.
    assign do_pop  = pop_i & ~is_empty;
    assign do_push = push_i & ~is_full & ~(bypass & pop_i);

    always_comb begin
        head_d  = do_pop  ? ptr_inc(head_q) : head_q;
        tail_d  = do_push ? ptr_inc(tail_q) : tail_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entries_q[i] <= PREG_W'(NUM_ARCH + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= FL_CNT_W'(FL_DEPTH);
        end else begin
            if (do_push) begin
                entries_q[tail_q] <= push_preg_i;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rename_prf_core.sv
// R10K-style rename core: map table with ready bits, free list and physical register file.
// Optional macro FREE_LIST_BYPASS_EN forwards a retiring preg to new_preg when the free list is empty.
module rename_prf_core
    import rename_prf_core_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              dispatch_en,
    input  logic [ARCH_W-1:0] dispatch_rs1,
    input  logic [ARCH_W-1:0] dispatch_rs2,
    input  logic [ARCH_W-1:0] dispatch_rd,
    input  logic              dispatch_has_dest,
    output logic [PREG_W-1:0] rs1_tag,
    output logic [PREG_W-1:0] rs2_tag,
    output logic              rs1_ready,
    output logic              rs2_ready,
    output logic [PREG_W-1:0] new_preg,
    output logic [PREG_W-1:0] old_preg,
    output logic              fl_empty,
    input  logic              cdb_en,
    input  logic [PREG_W-1:0] cdb_tag,
    input  logic              retire_en,
    input  logic [PREG_W-1:0] retire_old_preg,
    input  logic [PREG_W-1:0] rd_tag1,
    input  logic [PREG_W-1:0] rd_tag2,
    output logic [XLEN-1:0]   rd_data1,
    output logic [XLEN-1:0]   rd_data2,
    input  logic              wr_en,
    input  logic [PREG_W-1:0] wr_tag,
    input  logic [XLEN-1:0]   wr_data
);

    tag_t            map_q [NUM_ARCH];
    tag_t            map_d [NUM_ARCH];
    logic [XLEN-1:0] prf_q [NUM_PHYS];
    tag_t            src1, src2;
    logic            alloc, fl_push;

    // Sources see the pre-rename mapping, plus a same-cycle CDB wakeup.
    assign src1      = map_q[dispatch_rs1];
    assign src2      = map_q[dispatch_rs2];
    assign rs1_tag   = src1.phys_reg;
    assign rs2_tag   = src2.phys_reg;
    assign rs1_ready = src1.ready | (cdb_en & (cdb_tag == src1.phys_reg));
    assign rs2_ready = src2.ready | (cdb_en & (cdb_tag == src2.phys_reg));
    assign old_preg  = map_q[dispatch_rd].phys_reg;

    assign alloc   = dispatch_en & dispatch_has_dest & (dispatch_rd != '0) & ~fl_empty;
    assign fl_push = retire_en & (retire_old_preg != '0);

    rename_free_fifo u_free_fifo (
        .clock_i     (clock),
        .reset_i     (reset),
        .pop_i       (alloc),
        .push_i      (fl_push),
        .push_preg_i (retire_old_preg),
        .head_preg_o (new_preg),
        .empty_o     (fl_empty)
    );

    always_comb begin
        for (int i = 0; i < NUM_ARCH; i++) begin
            map_d[i] = map_q[i];
            if (cdb_en && (map_q[i].phys_reg == cdb_tag)) begin
                map_d[i].ready = 1'b1;
            end
        end
        if (alloc) begin
            map_d[dispatch_rd] = '{phys_reg: new_preg, ready: 1'b0};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                map_q[i] <= '{phys_reg: PREG_W'(i), ready: 1'b1};
            end
        end else begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                map_q[i] <= map_d[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                prf_q[i] <= '0;
            end
        end else if (wr_en && (wr_tag != '0)) begin
            prf_q[wr_tag] <= wr_data;
        end
    end

    // Preg 0 reads as zero; a same-cycle write is forwarded to matching readers.
    always_comb begin
        rd_data1 = prf_q[rd_tag1];
        if (rd_tag1 == '0) begin
            rd_data1 = '0;
        end else if (wr_en && (wr_tag == rd_tag1)) begin
            rd_data1 = wr_data;
        end
        rd_data2 = prf_q[rd_tag2];
        if (rd_tag2 == '0) begin
            rd_data2 = '0;
        end else if (wr_en && (wr_tag == rd_tag2)) begin
            rd_data2 = wr_data;
        end
    end

endmodule

// File: tb/tb_rename_prf_core.sv
// Randomized bench for rename_prf_core against a queue/array reference model.
module tb_rename_prf_core;
    import rename_prf_core_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              dispatch_en, dispatch_has_dest;
    logic [ARCH_W-1:0] dispatch_rs1, dispatch_rs2, dispatch_rd;
    logic [PREG_W-1:0] rs1_tag, rs2_tag, new_preg, old_preg;
    logic              rs1_ready, rs2_ready, fl_empty;
    logic              cdb_en, retire_en, wr_en;
    logic [PREG_W-1:0] cdb_tag, retire_old_preg, rd_tag1, rd_tag2, wr_tag;
    logic [XLEN-1:0]   rd_data1, rd_data2, wr_data;

    rename_prf_core dut (
        .clock (clock), .reset (reset),
        .dispatch_en (dispatch_en), .dispatch_rs1 (dispatch_rs1), .dispatch_rs2 (dispatch_rs2),
        .dispatch_rd (dispatch_rd), .dispatch_has_dest (dispatch_has_dest),
        .rs1_tag (rs1_tag), .rs2_tag (rs2_tag), .rs1_ready (rs1_ready), .rs2_ready (rs2_ready),
        .new_preg (new_preg), .old_preg (old_preg), .fl_empty (fl_empty),
        .cdb_en (cdb_en), .cdb_tag (cdb_tag),
        .retire_en (retire_en), .retire_old_preg (retire_old_preg),
        .rd_tag1 (rd_tag1), .rd_tag2 (rd_tag2), .rd_data1 (rd_data1), .rd_data2 (rd_data2),
        .wr_en (wr_en), .wr_tag (wr_tag), .wr_data (wr_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    preg_t           m_tag [NUM_ARCH];
    logic            m_rdy [NUM_ARCH];
    logic [XLEN-1:0] m_prf [NUM_PHYS];
    preg_t           fl [$];
    logic            e_empty, e_alloc, e_byp;
    preg_t           e_new;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        fl.delete();
        for (int i = 0; i < NUM_ARCH; i++) begin
            m_tag[i] = preg_t'(i);
            m_rdy[i] = 1'b1;
        end
        for (int i = 0; i < NUM_PHYS; i++) m_prf[i] = '0;
        for (int i = NUM_ARCH; i < NUM_PHYS; i++) fl.push_back(preg_t'(i));
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input preg_t t);
        if (t == 0) return '0;
        if (wr_en && wr_tag == t) return wr_data;
        return m_prf[t];
    endfunction

    task automatic idle();
        dispatch_en = 0; dispatch_has_dest = 0; dispatch_rs1 = 0; dispatch_rs2 = 0; dispatch_rd = 0;
        cdb_en = 0; cdb_tag = 0; retire_en = 0; retire_old_preg = 0;
        rd_tag1 = 0; rd_tag2 = 0; wr_en = 0; wr_tag = 0; wr_data = 0;
    endtask

    // Called at posedge+1; compares combinational outputs at posedge+4.
    task automatic settle();
        #3;
        e_byp = 1'b0;
`ifdef FREE_LIST_BYPASS_EN
        e_byp = (fl.size() == 0) && retire_en && (retire_old_preg != 0);
`endif
        e_empty = (fl.size() == 0) && !e_byp;
        e_new   = e_byp ? retire_old_preg : ((fl.size() != 0) ? fl[0] : '0);
        e_alloc = dispatch_en && dispatch_has_dest && (dispatch_rd != 0) && !e_empty;
        check("rs1_tag", 32'(rs1_tag), 32'(m_tag[dispatch_rs1]));
        check("rs1_ready", 32'(rs1_ready),
              32'(m_rdy[dispatch_rs1] || (cdb_en && cdb_tag == m_tag[dispatch_rs1])));
        check("rs2_tag", 32'(rs2_tag), 32'(m_tag[dispatch_rs2]));
        check("rs2_ready", 32'(rs2_ready),
              32'(m_rdy[dispatch_rs2] || (cdb_en && cdb_tag == m_tag[dispatch_rs2])));
        check("old_preg", 32'(old_preg), 32'(m_tag[dispatch_rd]));
        check("fl_empty", 32'(fl_empty), 32'(e_empty));
        if (!e_empty) check("new_preg", 32'(new_preg), 32'(e_new));
        check("rd_data1", rd_data1, exp_rd(rd_tag1));
        check("rd_data2", rd_data2, exp_rd(rd_tag2));
    endtask

    task automatic advance();
        int sz;
        @(posedge clock);
        if (cdb_en) begin
            for (int i = 0; i < NUM_ARCH; i++) if (m_tag[i] == cdb_tag) m_rdy[i] = 1'b1;
        end
        if (e_alloc) begin
            m_tag[dispatch_rd] = e_new;
            m_rdy[dispatch_rd] = 1'b0;
        end
        if (!(e_byp && e_alloc)) begin
            sz = fl.size();
            if (e_alloc) void'(fl.pop_front());
            if (retire_en && retire_old_preg != 0 && sz < NUM_PHYS - NUM_ARCH) fl.push_back(retire_old_preg);
        end
        if (wr_en && wr_tag != 0) m_prf[wr_tag] = wr_data;
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic rand_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            dispatch_en       = ($urandom_range(0, 3) != 0);
            dispatch_has_dest = ($urandom_range(0, 4) != 0);
            dispatch_rd       = ARCH_W'($urandom);
            dispatch_rs1      = ARCH_W'($urandom);
            dispatch_rs2      = ARCH_W'($urandom);
            cdb_en            = 1'($urandom);
            cdb_tag           = ($urandom_range(0, 1) != 0) ? m_tag[$urandom_range(0, NUM_ARCH-1)]
                                                            : PREG_W'($urandom);
            retire_en         = ($urandom_range(0, 9) < 4);
            retire_old_preg   = ($urandom_range(0, 15) == 0) ? '0 : PREG_W'($urandom_range(1, NUM_PHYS-1));
            wr_en             = 1'($urandom);
            wr_tag            = PREG_W'($urandom);
            wr_data           = $urandom;
            rd_tag1           = ($urandom_range(0, 2) == 0) ? wr_tag : PREG_W'($urandom);
            rd_tag2           = PREG_W'($urandom);
            cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_new_preg", 32'(new_preg), 32'd32);
        check("rst_fl_empty", 32'(fl_empty), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        dispatch_en = 1; dispatch_has_dest = 1; dispatch_rd = 3; dispatch_rs1 = 1; dispatch_rs2 = 2;
        settle();
        check("first_new", 32'(new_preg), 32'd32);
        check("first_old", 32'(old_preg), 32'd3);
        check("first_rs1", 32'({rs1_tag, rs1_ready}), 32'({6'd1, 1'b1}));
        check("first_rs2", 32'({rs2_tag, rs2_ready}), 32'({6'd2, 1'b1}));
        advance();
        dispatch_rs1 = 3; dispatch_rd = 5;
        settle();
        check("renamed_rs1", 32'({rs1_tag, rs1_ready}), 32'({6'd32, 1'b0}));
        check("second_new", 32'(new_preg), 32'd33);
        advance();

        dispatch_rs1 = 3; dispatch_rd = 3; cdb_en = 1; cdb_tag = 32;
        settle();
        check("cdb_bypass", 32'(rs1_ready), 32'd1);
        advance();
        dispatch_en = 0; cdb_tag = 33;
        settle();
        check("rename_beats_cdb", 32'({rs1_tag, rs1_ready}), 32'({6'd34, 1'b0}));
        advance();
        cdb_en = 0; dispatch_rs1 = 5;
        settle();
        check("cdb_committed", 32'(rs1_ready), 32'd1);
        advance();

        idle(); wr_en = 1; wr_tag = 32; wr_data = 5; rd_tag1 = 32;
        settle();
        check("prf_fwd", rd_data1, 32'd5);
        advance();
        wr_en = 0;
        settle();
        check("prf_held", rd_data1, 32'd5);
        advance();
        wr_en = 1; wr_tag = 0; wr_data = 7; rd_tag1 = 0; rd_tag2 = 0;
        settle();
        check("prf_zero_fwd", rd_data1, 32'd0);
        advance();
        wr_en = 0;
        settle();
        check("prf_zero_held", rd_data2, 32'd0);
        advance();

        idle(); dispatch_en = 1; dispatch_has_dest = 1; dispatch_rd = 0;
        settle();
        check("r0_map", 32'({rs1_tag, rs1_ready}), 32'({6'd0, 1'b1}));
        check("r0_head", 32'(new_preg), 32'd35);
        advance();
        dispatch_en = 0;
        settle();
        check("r0_head_kept", 32'(new_preg), 32'd35);
        advance();

        dispatch_en = 1;
        for (int k = 0; k < 40 && fl.size() != 0; k++) begin
            dispatch_rd = ARCH_W'(1 + k % 31);
            cycle();
        end
        dispatch_rd = 7; dispatch_rs1 = 7;
        settle();
        check("drained_empty", 32'(fl_empty), 32'd1);
        advance();
        dispatch_en = 0; retire_en = 1; retire_old_preg = 3;
        settle();
`ifdef FREE_LIST_BYPASS_EN
        check("bypass_new", 32'({fl_empty, new_preg}), 32'({1'b0, 6'd3}));
`else
        check("retire_still_empty", 32'(fl_empty), 32'd1);
`endif
        advance();
        retire_en = 0;
        settle();
        check("retire_freed", 32'({fl_empty, new_preg}), 32'({1'b0, 6'd3}));
        advance();

        rand_cycles(300);

        idle();
        #1 reset = 1'b1;
        model_reset();
        for (int i = 0; i < NUM_ARCH; i++) begin
            dispatch_rs1 = ARCH_W'(i); dispatch_rs2 = ARCH_W'(31 - i); dispatch_rd = ARCH_W'(i);
            rd_tag1 = PREG_W'(i); rd_tag2 = PREG_W'(i + 32);
            #1;
            check("rst_rs1", 32'({rs1_tag, rs1_ready}), 32'({6'(i), 1'b1}));
            check("rst_rs2", 32'({rs2_tag, rs2_ready}), 32'({6'(31 - i), 1'b1}));
            check("rst_old", 32'(old_preg), 32'(i));
            check("rst_prf", rd_data1 | rd_data2, 32'd0);
            check("rst_head", 32'({fl_empty, new_preg}), 32'({1'b0, 6'd32}));
            @(posedge clock); #2;
        end
        idle();
        reset = 1'b0;
        @(posedge clock); #1;

        rand_cycles(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
